// File: rtl/pkt_rx_ctrl.sv
// pkt_rx_ctrl: arms Shift_Buffer, hunts for a sync-qualified frame and hands its 44-bit payload downstream
module pkt_rx_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int TCNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        auto_rearm,
  input  logic [63:0] sb_dout,
  input  logic        sb_pkt_rec,
  output logic        sb_en,
  output logic        sb_rst,
  output logic [43:0] pkt_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic        busy,
  output logic        timeout,
  output logic [7:0]  frame_cnt
);
  typedef enum logic [1:0] {IDLE, FLUSH, HUNT, HOLD} state_t;
  state_t state;
  logic [TCNT_W-1:0] tcnt;
  logic expired;
  logic unused_sync;
  assign expired = (TIMEOUT != 0) && (tcnt == TCNT_W'(TIMEOUT - 1));
  assign unused_sync = ^{sb_dout[63:58], sb_dout[36:32], sb_dout[8:0]};
  // Sequencer; every output is registered together with the state it belongs to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sb_en     <= 1'b0;
      sb_rst    <= 1'b1;
      pkt_data  <= '0;
      pkt_valid <= 1'b0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      frame_cnt <= '0;
      tcnt      <= '0;
    end else if (abort) begin
      state     <= IDLE;
      sb_en     <= 1'b0;
      sb_rst    <= 1'b0;
      pkt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sb_en  <= 1'b0;
          sb_rst <= start;
          if (start) begin
            state   <= FLUSH;
            busy    <= 1'b1;
            timeout <= 1'b0;
          end
        end
        FLUSH: begin
          state  <= HUNT;
          sb_rst <= 1'b0;
          sb_en  <= 1'b1;
          tcnt   <= '0;
        end
        HUNT: begin
          tcnt <= tcnt + TCNT_W'(1);
          if (sb_pkt_rec) begin
            state     <= HOLD;
            sb_en     <= 1'b0;
            pkt_valid <= 1'b1;
            pkt_data  <= {sb_dout[57:37], sb_dout[31:9]};
          end else if (expired) begin
            state   <= IDLE;
            sb_en   <= 1'b0;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end
        end
        HOLD: begin
          if (pkt_valid && pkt_ready) begin
            pkt_valid <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= auto_rearm ? FLUSH : IDLE;
            sb_rst    <= auto_rearm;
            busy      <= auto_rearm;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
